// File: rtl/rx_note_filter.sv
// rtl/rx_note_filter.sv - UART note byte filter: instrument-ID check, byte FIFO, drop statistics.
// Optional RX_NOTE_TIMEOUT_EN adds per-instrument silence timers that inject release bytes.
module rx_note_filter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] drop_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop;
  logic        id_ok, rx_accept, rx_drop, ovf_set;
  logic        push;
  logic [7:0]  push_data;

  // The extra MSB tells a full FIFO from an empty one when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;

  assign id_ok     = $onehot(rx_data[2:0]);
  assign rx_accept = rx_valid && id_ok && (!full || pop);
  assign rx_drop   = rx_valid && (!id_ok || (full && !pop));
  assign ovf_set   = rx_valid && id_ok && full && !pop;

`ifdef RX_NOTE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    active;
  logic [CW-1:0] cnt [3];
  logic [2:0]    pending, rel_id;
  logic          rel_push;

  always_comb begin
    pending = '0;
    for (int i = 0; i < 3; i++) begin
      pending[i] = active[i] && (cnt[i] == T_MAX);
    end
  end

  // Lowest set bit wins: bass, then drum, then guitar.
  assign rel_id    = pending & (~pending + 3'd1);
  assign rel_push  = !rx_valid && !full && (|pending);
  assign push      = rx_accept || rel_push;
  assign push_data = rx_accept ? rx_data : {5'b00000, rel_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rx_accept && rx_data[i]) begin
          cnt[i]    <= '0;
          active[i] <= |rx_data[7:3];
        end else if (rel_push && rel_id[i]) begin
          cnt[i]    <= '0;
          active[i] <= 1'b0;
        end else if (active[i] && cnt[i] != T_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign push      = rx_accept;
  assign push_data = rx_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (rx_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_rx_note_filter.sv
// tb/tb_rx_note_filter.sv - self-checking bench for rx_note_filter (vector table, reference model, corner sequences).
module tb_rx_note_filter;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] drop_count;
  logic       overflow;

  rx_note_filter #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  int m_drop;
  bit m_ovf;
  int m_act[3];
  int m_cnt[3];

  typedef struct {
    bit         rv;
    logic [7:0] d;
    bit         rdy;
    bit         ev;
    logic [7:0] ed;
    logic [7:0] edrop;
    bit         eovf;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  // Reference behaviour of one clock edge, from the pre-edge model state.
  task automatic model_step(input bit rv, input logic [7:0] d, input bit rdy);
    int sz;
    bit pop, ok, acc;
    sz  = mq.size();
    pop = (sz > 0) && rdy;
    ok  = (d[2:0] == 3'd1) || (d[2:0] == 3'd2) || (d[2:0] == 3'd4);
    acc = 1'b0;
    if (rv) begin
      if (ok && (sz < DEPTH || pop)) acc = 1'b1;
      else begin
        if (m_drop < 255) m_drop++;
        if (ok) m_ovf = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(d);
`ifdef RX_NOTE_TIMEOUT_EN
    begin
      int rel;
      rel = -1;
      if (!rv && sz < DEPTH) begin
        for (int i = 0; i < 3; i++)
          if (rel < 0 && m_act[i] != 0 && m_cnt[i] == TMO - 1) rel = i;
      end
      if (rel >= 0) mq.push_back(8'(1 << rel));
      for (int i = 0; i < 3; i++) begin
        if (acc && d[i]) begin
          m_cnt[i] = 0;
          m_act[i] = (d[7:3] != 5'd0) ? 1 : 0;
        end else if (rel == i) begin
          m_cnt[i] = 0;
          m_act[i] = 0;
        end else if (m_act[i] != 0 && m_cnt[i] < TMO - 1) begin
          m_cnt[i]++;
        end
      end
    end
`endif
  endtask

  task automatic model_chk(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".data"}, 32'(out_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit rv, input logic [7:0] d, input bit rdy);
    rx_valid  = rv;
    rx_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_step(rv, d, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.data", 32'(out_data), 32'h0);
    chk("rst.drop", 32'(drop_count), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [2:0] id;
    logic [4:0] pl;
    case ($urandom_range(0, 4))
      0: id = 3'd1;
      1: id = 3'd2;
      2: id = 3'd4;
      default: id = 3'($urandom_range(0, 7));
    endcase
    pl = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return {pl, id};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    tbl[0]  = '{1'b1, 8'h29, 1'b1, 1'b1, 8'h29, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h0B, 1'b1, 1'b0, 8'h00, 8'd1, 1'b0};
    tbl[4]  = '{1'b1, 8'h28, 1'b1, 1'b0, 8'h00, 8'd2, 1'b0};
    tbl[5]  = '{1'b1, 8'h09, 1'b0, 1'b1, 8'h09, 8'd2, 1'b0};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h09, 8'd2, 1'b0};
    tbl[7]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h09, 8'd2, 1'b0};
    tbl[8]  = '{1'b1, 8'h21, 1'b0, 1'b1, 8'h09, 8'd2, 1'b0};
    tbl[9]  = '{1'b1, 8'h2A, 1'b0, 1'b1, 8'h09, 8'd3, 1'b1};
    tbl[10] = '{1'b1, 8'h34, 1'b1, 1'b1, 8'h12, 8'd3, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1C, 8'd3, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 8'd3, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 8'd3, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd3, 1'b1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rv, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d.drop", i), 32'(drop_count), 32'(tbl[i].edrop));
      chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(tbl[i].eovf));
    end

    // Sparse traffic lets silence timers expire; dense traffic exercises full/overflow.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 7) == 0, rand_byte(), $urandom_range(0, 3) != 0);
      model_chk("rnd_sparse");
    end
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 1) == 1, rand_byte(), $urandom_range(0, 9) < 3);
      model_chk("rnd_dense");
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'h00, 1'b1);
      model_chk("sat");
    end
    chk("drop_saturated", 32'(drop_count), 32'd255);

`ifdef RX_NOTE_TIMEOUT_EN
    begin
      int hits, at;
      do_reset();
      cycle(1'b1, 8'hFC, 1'b1);
      hits = 0;
      at = -1;
      for (int k = 1; k <= 40; k++) begin
        cycle(1'b0, 8'h00, 1'b1);
        model_chk("tmo");
        if (out_valid && out_data == 8'h04) begin
          hits++;
          if (at < 0) at = k;
        end
      end
      chk("tmo_once", 32'(hits), 32'd1);
      chk("tmo_at", 32'(at), 32'd16);
    end

    for (int s = 0; s < 2; s++) begin
      do_reset();
      cycle(1'b1, 8'h09, 1'b1);
      cycle(1'b1, 8'h0C, 1'b1);
      repeat (20) cycle(1'b1, 8'h00, 1'b1);
      if (s == 1) begin
        cycle(1'b1, 8'h0A, 1'b1);
        chk("prio.rx_first", 32'(out_data), 32'h0A);
      end
      cycle(1'b0, 8'h00, 1'b1);
      chk("rel.bass_valid", 32'(out_valid), 32'h1);
      chk("rel.bass", 32'(out_data), 32'h01);
      cycle(1'b0, 8'h00, 1'b1);
      chk("rel.guitar_valid", 32'(out_valid), 32'h1);
      chk("rel.guitar", 32'(out_data), 32'h04);
      cycle(1'b0, 8'h00, 1'b1);
      chk("rel.done", 32'(out_valid), 32'h0);
    end
`endif

    do_reset();
    cycle(1'b1, 8'h09, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    repeat (20) cycle(1'b1, 8'h00, 1'b0);
    model_chk("pre_rst");
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.valid", 32'(out_valid), 32'h0);
    chk("async_rst.data", 32'(out_data), 32'h0);
    chk("async_rst.drop", 32'(drop_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (out_valid) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_note_filter.md
RX_NOTE_FILTER -- requirements
Module: rx_note_filter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of byte entries; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 27000000, SHALL set the silence interval, in clk cycles, after which a held note is released.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx_valid  input  1  SHALL be a one-cycle strobe from the UART receiver (RxD_data_ready).
REQ-006 rx_data  input  8  SHALL carry the received byte: [2:0] instrument ID (001 bass, 010 drum, 100 guitar), [7:3] payload.
REQ-007 out_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-008 out_data  output  8  SHALL be the FIFO head byte, in the same format as rx_data.
REQ-009 out_ready  input  1  SHALL be the downstream (instrument decoder) acceptance signal.
REQ-010 drop_count  output  8  SHALL count dropped bytes and saturate at 255.
REQ-011 overflow  output  1  SHALL be a sticky flag set by any FIFO-full drop.

Function
REQ-012 A byte SHALL be valid only when rx_data[2:0] has exactly one bit set; invalid bytes SHALL be discarded and SHALL increment drop_count.
REQ-013 A valid byte SHALL be written to the FIFO on the edge where rx_valid=1; out_valid SHALL be high from the next cycle (latency 1).
REQ-014 A pop SHALL occur on any edge with out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-015 When the FIFO is full, a valid byte SHALL be accepted only if a pop occurs on the same edge; otherwise it SHALL be dropped, drop_count SHALL increment, and overflow SHALL set.
REQ-016 Write and read pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished with an extra pointer bit.
REQ-017 Each instrument SHALL have an active flag and a silence counter; an accepted byte for that instrument SHALL clear its counter.
REQ-018 The active flag SHALL be set when the accepted payload is non-zero (for drum, rx_data[7:3]) and cleared when the payload is zero.
REQ-019 The silence counter SHALL increment only while the instrument is active, and it SHALL saturate at TIMEOUT_CYCLES-1.
REQ-020 When the counter of an active instrument reaches TIMEOUT_CYCLES-1, a release request SHALL be raised for the byte {5'b00000, ID}.
REQ-021 A pending release SHALL be pushed only on a cycle with no rx_valid and with FIFO space; the UART byte SHALL always have priority, and the release SHALL retry on later cycles.
REQ-022 Simultaneous pending releases SHALL be injected one per cycle in the fixed order bass, drum, guitar.
REQ-023 A pushed release SHALL clear that instrument's active flag and counter; an accepted UART byte for the same instrument SHALL cancel its pending release.
REQ-024 Releases SHALL never be dropped and SHALL never affect drop_count or overflow.

Reset
REQ-025 While rst_n=0: FIFO pointers SHALL be 0, out_valid=0, out_data=8'h00, drop_count=0, overflow=0, all active flags, counters and pending releases SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all FIFO contents immediately, with no release bytes emitted.

Configuration
REQ-027 With macro RX_NOTE_TIMEOUT_EN defined, REQ-017 to REQ-024 SHALL be implemented.
REQ-028 Without RX_NOTE_TIMEOUT_EN, there SHALL be no counters or release logic, and the FIFO SHALL carry only UART bytes.

Verification
REQ-029 Reset, then rx 8'h29 (bass, payload 5) with out_ready=1 -> out_valid=1 for exactly one cycle with out_data=8'h29, one cycle after the strobe.
REQ-030 rx 8'h0B (ID 011) then 8'h28 (ID 000) -> nothing output, drop_count=2, overflow=0.
REQ-031 out_ready=0, push 5 valid bytes with FIFO_DEPTH=4 -> first 4 held in order, 5th dropped, drop_count=1, overflow=1; push coinciding with a pop when full -> accepted, no drop.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=16, rx 8'hFC (guitar, payload 31), then silence -> 8'h04 output once after 16 cycles, and none thereafter.
REQ-033 TIMEOUT_EN, bass and guitar active and timing out on the same cycle, out_ready=1 -> 8'h01 then 8'h04 on consecutive cycles; an rx byte on the injection cycle is output first.
REQ-034 Assert rst_n=0 with 3 entries queued and a release pending -> out_valid=0 immediately, and after deassertion no bytes are output.
